// File: rtl/fp8_mult_result_collector_if.sv
// Handshake bundle between the FP8 multiplier, the result collector and its consumer.
//   in_*  : product stream from the multiplier (valid/ready)
//   out_* : buffered product stream to the consumer (valid/ready)
// Modports: slave = collector view, master = producer/consumer (testbench) view.
interface fp8_mult_result_collector_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [4:0] in_flags;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [4:0] out_flags;

    modport slave (
        input  in_valid, in_result, in_flags, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

    modport master (
        output in_valid, in_result, in_flags, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp8_mult_result_collector.sv
// Result collector behind the combinational FP8 (1/3/4) multiplier.
// Buffers product + IEEE flags in a DEPTH-entry FIFO, keeps sticky exception
// status with a maskable interrupt and a saturating count of exceptional results.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : in_* producer handshake and out_* consumer handshake
//   count        : FIFO occupancy
//   sticky_flags : OR of flags of all accepted entries since last clear
//   sticky_clr   : synchronous clear of sticky_flags and exc_count
//   flag_mask    : per-flag interrupt enable
//   irq          : |(sticky_flags & flag_mask)
//   exc_count    : saturating count of accepted entries with flags[4:1] != 0
module fp8_mult_result_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    fp8_mult_result_collector_if.slave bus,
    output logic [$clog2(DEPTH):0]    count,
    output logic [4:0]                sticky_flags,
    input  logic                      sticky_clr,
    input  logic [4:0]                flag_mask,
    output logic                      irq,
    output logic [CNT_W-1:0]          exc_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CNT_W-1:0] ExcMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} occ_e;

    occ_e            occ_q, occ_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      res_q [DEPTH];
    logic [7:0]      res_d [DEPTH];
    logic [4:0]      flg_q [DEPTH];
    logic [4:0]      flg_d [DEPTH];
    logic [4:0]      sticky_q, sticky_d;
    logic [CNT_W-1:0] exc_q, exc_d;

    logic push, pop, is_exc;

    // Handshake outputs come from registered occupancy state only, so there
    // is no combinational path from out_ready to in_ready.
    assign bus.in_ready  = (occ_q != StFull);
    assign bus.out_valid = (occ_q != StEmpty);
    assign bus.out_result = bus.out_valid ? res_q[rd_ptr_q] : 8'h00;
    assign bus.out_flags  = bus.out_valid ? flg_q[rd_ptr_q] : 5'h00;

    assign push   = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;
    assign is_exc = push & (|bus.in_flags[4:1]);

    assign count        = count_q;
    assign sticky_flags = sticky_q;
    assign exc_count    = exc_q;
    assign irq          = |(sticky_q & flag_mask);

    always_comb begin
        res_d    = res_q;
        flg_d    = flg_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            res_d[wr_ptr_q] = bus.in_result;
            flg_d[wr_ptr_q] = bus.in_flags;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (count_d == '0) begin
            occ_d = StEmpty;
        end else if (count_d == CntW'(DEPTH)) begin
            occ_d = StFull;
        end else begin
            occ_d = StPartial;
        end
    end

    // A clear coinciding with a push keeps that push's event.
    always_comb begin
        sticky_d = sticky_q;
        exc_d    = exc_q;
        if (sticky_clr) begin
            sticky_d = push ? bus.in_flags : 5'h00;
            exc_d    = is_exc ? CNT_W'(1) : '0;
        end else begin
            if (push) begin
                sticky_d = sticky_q | bus.in_flags;
            end
            if (is_exc && (exc_q != ExcMax)) begin
                exc_d = exc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= StEmpty;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            exc_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            exc_q    <= exc_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
        end
    end
endmodule

// File: tb/tb_fp8_mult_result_collector.sv
module tb_fp8_mult_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp8_mult_result_collector_if bus ();
    fp8_mult_result_collector_if sat_bus ();

    logic [2:0] count;
    logic [4:0] sticky_flags;
    logic       sticky_clr;
    logic [4:0] flag_mask;
    logic       irq;
    logic [7:0] exc_count;

    logic [2:0] sat_count;
    logic [4:0] sat_sticky;
    logic       sat_clr;
    logic       sat_irq;
    logic [1:0] sat_exc;

    fp8_mult_result_collector #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .count        (count),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .flag_mask    (flag_mask),
        .irq          (irq),
        .exc_count    (exc_count)
    );

    fp8_mult_result_collector #(.DEPTH(4), .CNT_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .bus          (sat_bus.slave),
        .count        (sat_count),
        .sticky_flags (sat_sticky),
        .sticky_clr   (sat_clr),
        .flag_mask    (5'h00),
        .irq          (sat_irq),
        .exc_count    (sat_exc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted inputs, compare every consumed output in order.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_on_empty_scoreboard", {19'd0, bus.out_flags, bus.out_result}, 32'h1fff);
            end else begin
                check("pop_entry", {19'd0, bus.out_flags, bus.out_result},
                      {19'd0, exp_q.pop_front()});
            end
        end
        if (bus.in_valid && bus.in_ready && !rst) begin
            exp_q.push_back({bus.in_flags, bus.in_result});
        end
    end

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (count == 0) break;
            tick();
        end
        bus.out_ready = 1'b0;
        check(name, count, 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_result = 0; bus.in_flags = 0; bus.out_ready = 0;
        sat_bus.in_valid = 0; sat_bus.in_result = 0; sat_bus.in_flags = 0;
        sat_bus.out_ready = 0;
        sticky_clr = 0; sat_clr = 0; flag_mask = 5'b00100;

        // Reset values
        #2;
        check("rst_count", count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_irq", irq, 0);
        check("rst_exc", exc_count, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single push, stall, then pop
        bus.in_valid = 1; bus.in_result = 8'h4A; bus.in_flags = 0;
        tick();
        bus.in_valid = 0;
        check("single_valid", bus.out_valid, 1);
        check("single_result", bus.out_result, 8'h4A);
        check("single_count", count, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_stable", {bus.out_valid, bus.out_result}, {1'b1, 8'h4A});
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        check("single_pop_count", count, 0);
        check("single_pop_result", bus.out_result, 0);

        // Fill, refuse fifth, then drain with wrap
        bus.in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_result = 8'(i * 8'h11);
            tick();
        end
        bus.in_result = 8'h55;
        check("full_count", count, 4);
        check("full_in_ready", bus.in_ready, 0);
        tick();
        check("refused_count", count, 4);
        check("refused_head", bus.out_result, 8'h11);
        bus.out_ready = 1;
        tick();
        tick();
        bus.in_valid = 0;
        drain("fill_drain");

        // Concurrent push/pop at count=2
        bus.in_valid = 1;
        bus.in_result = 8'h60; tick();
        bus.in_result = 8'h61; tick();
        check("pp_start_count", count, 2);
        bus.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            bus.in_result = 8'(8'h62 + i);
            tick();
            check("pp_count", count, 2);
        end
        bus.in_valid = 0;
        drain("pp_drain");

        // Sticky flags, exc_count, irq
        bus.in_valid = 1; bus.in_result = 8'h01; bus.in_flags = 5'b00001;
        tick();
        check("sticky_inexact", sticky_flags, 5'b00001);
        check("irq_inexact", irq, 0);
        check("exc_inexact", exc_count, 0);
        bus.in_result = 8'h02; bus.in_flags = 5'b00100;
        tick();
        check("sticky_ovf", sticky_flags, 5'b00101);
        check("irq_ovf", irq, 1);
        check("exc_ovf", exc_count, 1);
        sticky_clr = 1; bus.in_result = 8'h03; bus.in_flags = 5'b10000;
        tick();
        sticky_clr = 0; bus.in_valid = 0; bus.in_flags = 0;
        check("sticky_clr_push", sticky_flags, 5'b10000);
        check("exc_clr_push", exc_count, 1);
        check("irq_clr_push", irq, 0);
        flag_mask = 5'b10000;
        #1 check("irq_mask_follow", irq, 1);
        flag_mask = 5'b00100;
        check("pre_reset_count", count, 3);

        // Asynchronous reset between edges
        #1 rst = 1;
        #1;
        check("async_count", count, 0);
        check("async_out_valid", bus.out_valid, 0);
        check("async_out_result", bus.out_result, 0);
        check("async_in_ready", bus.in_ready, 1);
        check("async_sticky", sticky_flags, 0);
        check("async_exc", exc_count, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 0;
        bus.in_valid = 1; bus.in_result = 8'h7E; bus.in_flags = 0;
        tick();
        bus.in_valid = 0;
        check("post_reset_result", bus.out_result, 8'h7E);
        check("post_reset_count", count, 1);
        drain("post_reset_drain");

        // Saturation with CNT_W=2
        sat_bus.in_valid = 1; sat_bus.in_result = 8'h08; sat_bus.in_flags = 5'b01000;
        sat_bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat_exc", sat_exc, (i + 1 > 3) ? 3 : i + 1);
        end
        sat_bus.in_valid = 0;
        sat_clr = 1;
        tick();
        sat_clr = 0;
        check("sat_clr", sat_exc, 0);

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/fp8_mult_result_collector.md
Name: fp8_mult_result_collector

Overview:
- Stage directly downstream of the combinational 8-bit FP multiplier (1 sign / 3 exponent / 4 mantissa bits).
- Captures each product and its 5-bit IEEE754 exception flags under a valid/ready handshake and buffers them in a small FIFO.
- Keeps sticky exception status with a maskable interrupt, plus a saturating count of exceptional results.
- Decouples the multiplier's combinational output from a consumer that can stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the exceptional-result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  multiplier output (in_result/in_flags) is valid this cycle.
- in_ready  output  1  collector can accept an entry this cycle.
- in_result  input  8  product from the multiplier.
- in_flags  input  5  product flags: [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow, [0] inexact.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes the head entry.
- out_result  output  8  head product.
- out_flags  output  5  head flags.
- count  output  $clog2(DEPTH)+1  current occupancy.
- sticky_flags  output  5  OR of the flags of all accepted entries since the last clear.
- sticky_clr  input  1  synchronous clear of sticky_flags and exc_count.
- flag_mask  input  5  interrupt enable per flag bit.
- irq  output  1  |(sticky_flags & flag_mask).
- exc_count  output  CNT_W  saturating count of accepted entries with any of in_flags[4:1] set.

Behaviour:
- Reset, asynchronous, while rst=1:
  - count=0, both pointers=0, storage=0, sticky_flags=0, exc_count=0.
  - Consequently out_valid=0, in_ready=1, irq=0, out_result=0, out_flags=0.
- Reset asserted mid-operation discards all buffered entries immediately. The first push after deassertion lands in entry 0.
- Push: push = in_valid & in_ready. Write the entry at wr_ptr, then wr_ptr++ with modulo-DEPTH wrap.
- Pop: pop = out_valid & out_ready. Advance rd_ptr with modulo-DEPTH wrap.
- in_ready = (count != DEPTH). It is registered state only; there is no combinational path from out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_result and out_flags:
  - Show the entry at rd_ptr when out_valid=1.
  - Forced to 0 when out_valid=0.
  - Must stay stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 at the earliest, when the FIFO was empty. There is no fall-through in the same cycle.
- Occupancy update:
  - Push without pop: count+1.
  - Pop without push: count-1.
  - Push and pop together (only possible when 0<count<DEPTH): count unchanged.
- Occupancy state machine, derived from count:
  - EMPTY (count=0): push goes to PARTIAL, or to FULL if DEPTH=1 (disallowed).
  - PARTIAL: push-only at count=DEPTH-1 goes to FULL; pop-only at count=1 goes to EMPTY; otherwise stays in PARTIAL.
  - FULL: pop goes to PARTIAL.
- in_valid while in_ready=0: no state change. The upstream side must hold the data; the collector neither drops nor overwrites it.
- Sticky flags:
  - On push: sticky_flags <= sticky_flags | in_flags.
  - sticky_clr without push: sticky_flags <= 0.
  - sticky_clr with push in the same cycle: sticky_flags <= in_flags (the new event is not lost).
- exc_count:
  - On a push with |in_flags[4:1]: increments.
  - Saturates at 2^CNT_W-1 with no wrap.
  - sticky_clr with such a push: exc_count <= 1.
  - sticky_clr alone: exc_count <= 0.
  - Inexact-only results never count.
- irq is combinational from the sticky register and flag_mask. It follows mask changes in the same cycle.
- All arithmetic on pointers and count is unsigned. The pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then single push: in_result=0x4A, in_flags=0, out_ready=0.
  - Next cycle: out_valid=1, out_result=0x4A, count=1.
  - Hold out_ready=0 for 3 cycles: outputs stable.
  - Pulse out_ready: count=0 and out_result=0 the following cycle.
- Fill: push 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - count=4, in_ready=0.
  - A fifth in_valid with 0x55 is not accepted.
  - Then pop all four in order 0x11..0x44, and push 0x55 once in_ready=1.
  - Covers pointer wrap on the next 4-entry cycle.
- Simultaneous push/pop at count=2 over 10 cycles with incrementing data:
  - count stays 2.
  - Output order matches input order exactly.
- Sticky and irq: flag_mask=5'b00100.
  - Push flags 5'b00001: sticky=00001, irq=0, exc_count=0.
  - Push flags 5'b00100: sticky=00101, irq=1, exc_count=1.
  - Assert sticky_clr together with a push of 5'b10000: sticky=10000, exc_count=1, irq=0.
- Saturation with CNT_W=2: push 5 entries with flags 5'b01000.
  - exc_count=3 and holds at 3.
- Asynchronous reset mid-stream: count=3, assert rst between clock edges.
  - Outputs go to reset values immediately, before the next edge.
  - After release, a push of 0x7E appears as the next out_result.
